i2s_stream_tx: RTL
==================

I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

Interface
REQ-001 SHALL have parameter AUDIO_DW, default 16, sample width in bits per channel.
REQ-002 SHALL have parameter SLOT_W, default 32, sclk cycles per channel slot; elaboration SHALL fail unless SLOT_W >= AUDIO_DW+1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, stereo-sample FIFO entries; elaboration SHALL fail unless it is a power of two >= 2.
REQ-004 SHALL have parameter DIV_W, default 16, width of clk_div.
REQ-005 SHALL have the following ports (one clock; reset is asynchronous and active-low):
  clk  in  1  system clock, all logic on rising edge
  rst_n  in  1  asynchronous active-low reset
  enable  in  1  1 = run serial interface, 0 = idle
  mode  in  1  0 = I2S (1-bit MSB delay), 1 = left-justified
  clk_div  in  DIV_W  sclk half-period minus one, in clk cycles
  s_valid  in  1  sample pair offered
  s_ready  out  1  FIFO can accept
  s_left  in  AUDIO_DW  left sample, two's complement
  s_right  in  AUDIO_DW  right sample
  fifo_level  out  clog2(FIFO_DEPTH)+1  entries held
  underrun  out  1  one-clk pulse, frame started with empty FIFO
  sclk  out  1  bit clock, registered
  lrclk  out  1  0 = left slot, 1 = right slot, registered
  sdata  out  1  serial data, registered

Function
REQ-006 s_ready SHALL equal (fifo_level != FIFO_DEPTH); push occurs on s_valid && s_ready.
REQ-007 FIFO SHALL be first-in first-out; fifo_level SHALL update the clk after push/pop; simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-008 While enable = 1, a divider counter SHALL count 0..clk_div; at clk_div it SHALL wrap to 0 and sclk SHALL toggle (half-period = clk_div+1 clks; clk_div = 0 gives sclk = clk/2).
REQ-009 clk_div changes SHALL take effect at the next divider comparison; no glitch shorter than one clk on sclk.
REQ-010 lrclk and sdata SHALL change only in the clk that sclk falls (1->0), plus the frame-start cycle in REQ-013.
REQ-011 A bit counter SHALL track slot position p (0..SLOT_W-1) and channel; p advances on each sclk fall, and wraps at SLOT_W-1 to p = 0 of the other channel.
REQ-012 lrclk SHALL equal the current channel, changing when p becomes 0, in both modes.
REQ-013 Frame start (p = 0, left channel): if fifo_level > 0 pop one pair into holding registers, else load zeros and pulse underrun for exactly one clk; mode SHALL be sampled only at frame start.
REQ-014 sdata at position p SHALL be sample[AUDIO_DW-1-d] with d = p-1 (I2S) or d = p (left-justified) when 0 <= d < AUDIO_DW, otherwise 0.
REQ-015 A push in the same clk as a frame start with an empty FIFO SHALL NOT be bypassed; underrun SHALL occur, and the sample SHALL be used at the next frame.
REQ-016 On enable 0->1, the next clk SHALL be a frame start with sclk = 0, divider = 0.
REQ-017 On enable 1->0, the next clk SHALL force sclk = 0, lrclk = 0, sdata = 0, counters to 0, abandoning the current frame; FIFO contents and push acceptance SHALL be unaffected.
REQ-018 Frame period SHALL be exactly 4*SLOT_W*(clk_div+1) clks.

Reset
REQ-019 rst_n low SHALL asynchronously clear FIFO (fifo_level = 0, s_ready = 1), counters, holding registers; sclk = 0, lrclk = 0, sdata = 0, underrun = 0.
REQ-020 Reset release SHALL be synchronised internally; first frame start SHALL occur no earlier than the second clk after release with enable = 1.
REQ-021 Reset asserted mid-frame SHALL drop the frame and all queued samples.

Verification
REQ-022 Defaults, clk_div = 1, mode = 0, push L = 0x8001, R = 0x7FFE -> sclk period 4 clks; left slot bits p1..p16 = 1000000000000001, p0 and p17..p31 = 0; lrclk 0 for 32 sclks then 1; frame = 256 clks.
REQ-023 Same data, mode = 1 -> MSB at p = 0 coincident with lrclk edge; p16..p31 = 0.
REQ-024 enable = 1 with empty FIFO -> underrun single-clk pulse each frame, sdata constant 0, sclk/lrclk still toggle.
REQ-025 Push 5 pairs with FIFO_DEPTH = 4, no drain -> s_ready low after 4th, fifo_level = 4, 5th held until first pop; samples emitted in push order.
REQ-026 Deassert enable at left p = 10, reassert 7 clks later -> outputs 0 next clk, new frame starts with next FIFO entry, fifo_level unchanged while idle.
REQ-027 rst_n pulsed low mid-frame with fifo_level = 3 -> all outputs 0 immediately, fifo_level = 0, s_ready = 1.

Source files
------------

// File: rtl/i2s_stream_tx.sv
// I2S / left-justified serial audio transmitter with a stereo-sample FIFO.
// The serial clock is divided from clk; the FIFO is popped once per frame at left slot position 0.
module i2s_stream_tx #(
    parameter int AUDIO_DW   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            mode,
    input  logic [DIV_W-1:0]                clk_div,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [AUDIO_DW-1:0]             s_left,
    input  logic [AUDIO_DW-1:0]             s_right,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun,
    output logic                            sclk,
    output logic                            lrclk,
    output logic                            sdata
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int PW    = $clog2(SLOT_W);
    localparam logic [PW-1:0] POS_LAST = PW'(SLOT_W - 1);

    if (SLOT_W < AUDIO_DW + 1) begin : g_bad_slot
        $error("i2s_stream_tx: SLOT_W must be at least AUDIO_DW+1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2s_stream_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [1:0]              sync_q;
    logic                    run_en;
    logic                    running_q, running_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic                    chan_q, chan_d;
    logic                    sclk_q, sclk_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;
    logic                    underrun_q, underrun_d;
    logic                    mode_q, mode_d;
    logic [AUDIO_DW-1:0]     hold_l_q, hold_l_d;
    logic [AUDIO_DW-1:0]     hold_r_q, hold_r_d;
    logic                    frame_start;
    logic                    bit_edge;
    logic                    push;
    logic                    pop;

    logic [2*AUDIO_DW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [2*AUDIO_DW-1:0]   head;
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q;

    // Bit for slot position p; I2S delays the MSB by one sclk.
    function automatic logic slot_bit(input logic [AUDIO_DW-1:0] smp,
                                      input logic [PW-1:0]       p,
                                      input logic                lj);
        int   d;
        logic b;
        d = int'(p) - (lj ? 0 : 1);
        b = 1'b0;
        if (d >= 0 && d < AUDIO_DW) begin
            b = smp[AUDIO_DW-1-d];
        end
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run_en  = enable & sync_q[1];
    assign s_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push    = s_valid & s_ready;
    assign head    = fifo_mem[rd_ptr_q];

    always_comb begin
        running_d   = running_q;
        div_d       = div_q;
        pos_d       = pos_q;
        chan_d      = chan_q;
        sclk_d      = sclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        mode_d      = mode_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        underrun_d  = 1'b0;
        frame_start = 1'b0;
        bit_edge    = 1'b0;
        pop         = 1'b0;

        if (!run_en) begin
            running_d = 1'b0;
            div_d     = '0;
            pos_d     = '0;
            chan_d    = 1'b0;
            sclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end else if (!running_q) begin
            running_d   = 1'b1;
            div_d       = '0;
            pos_d       = '0;
            chan_d      = 1'b0;
            sclk_d      = 1'b0;
            frame_start = 1'b1;
            bit_edge    = 1'b1;
        end else if (div_q >= clk_div) begin
            // >= so a clk_div reduced below the running count wraps at once
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                bit_edge = 1'b1;
                if (pos_q == POS_LAST) begin
                    pos_d       = '0;
                    chan_d      = ~chan_q;
                    frame_start = chan_q;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Level is the registered value, so a same-clk push is never bypassed.
        if (frame_start) begin
            mode_d     = mode;
            pop        = (level_q != '0);
            underrun_d = ~pop;
            hold_l_d   = pop ? head[2*AUDIO_DW-1:AUDIO_DW] : '0;
            hold_r_d   = pop ? head[AUDIO_DW-1:0] : '0;
        end

        if (bit_edge) begin
            lrclk_d = chan_d;
            sdata_d = slot_bit(chan_d ? hold_r_d : hold_l_d, pos_d, mode_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q  <= 1'b0;
            div_q      <= '0;
            pos_q      <= '0;
            chan_q     <= 1'b0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            mode_q     <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
        end else begin
            running_q  <= running_d;
            div_q      <= div_d;
            pos_q      <= pos_d;
            chan_q     <= chan_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            mode_q     <= mode_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {s_left, s_right};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign sclk       = sclk_q;
    assign lrclk      = lrclk_q;
    assign sdata      = sdata_q;

endmodule
